imm_gen_pipe: RTL and testbench

Parametrised immediate generator with an elastic output stage. It sits between instruction decode and the ID/EX pipeline register. It extracts the immediate selected by the decoder for every RV32/RV64 format, applies sign or zero extension to XLEN, and carries a sideband tag through unchanged. A 2-entry skid buffer with valid/ready handshake lets the EX stall without the decoder re-driving the instruction.

---
 rtl/imm_gen_pipe_if.sv | 30 +++
 rtl/imm_gen_pipe.sv | 131 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Decode-to-EX bus of the immediate generator: an instruction/select/tag request side
// and an immediate/tag/error response side.
// Handshake: a transfer occurs on a rising edge where VALID && READY; the producer may
// raise VALID at any time, READY never depends combinationally on VALID, and a response
// that is valid but not accepted keeps its payload stable.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [31:0]      INST;
    logic [3:0]       SELECT;
    logic [TAG_W-1:0] IN_TAG;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [XLEN-1:0]  OUT_IMM;
    logic [TAG_W-1:0] OUT_TAG;
    logic             OUT_ERR;

    modport master (
        output IN_VALID, INST, SELECT, IN_TAG, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_IMM, OUT_TAG, OUT_ERR
    );

    modport slave (
        input  IN_VALID, INST, SELECT, IN_TAG, OUT_READY,
        output IN_READY, OUT_VALID, OUT_IMM, OUT_TAG, OUT_ERR
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32/RV64 immediate extraction feeding a 2-entry skid buffer (head + skid register);
// the buffer occupancy is also exported as a debug output.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          FLUSH,
    imm_gen_pipe_if.slave bus,
    output logic [1:0]    occupancy
);
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    occ_e             state_q, state_d;
    logic [XLEN-1:0]  ext_imm, head_imm, skid_imm;
    logic             ext_err, head_err, skid_err;
    logic [TAG_W-1:0] head_tag, skid_tag;
    logic             push, pop;
    logic             load_head_new, load_head_skid, load_skid;
    logic             sx;
    logic             unused_opcode;

    assign sx            = ~bus.SELECT[3];
    assign unused_opcode = ^bus.INST[6:0];

    always_comb begin
        ext_imm = '0;
        ext_err = 1'b0;
        case (bus.SELECT[2:0])
            3'd0: ext_imm = sx ? XLEN'($signed({bus.INST[31:12], 12'b0}))
                               : XLEN'({bus.INST[31:12], 12'b0});
            3'd1: ext_imm = sx ? XLEN'($signed({bus.INST[31], bus.INST[19:12], bus.INST[20],
                                                bus.INST[30:21], 1'b0}))
                               : XLEN'({bus.INST[31], bus.INST[19:12], bus.INST[20],
                                        bus.INST[30:21], 1'b0});
            3'd2: ext_imm = sx ? XLEN'($signed(bus.INST[31:20])) : XLEN'(bus.INST[31:20]);
            3'd3: ext_imm = sx ? XLEN'($signed({bus.INST[31], bus.INST[7], bus.INST[30:25],
                                                bus.INST[11:8], 1'b0}))
                               : XLEN'({bus.INST[31], bus.INST[7], bus.INST[30:25],
                                        bus.INST[11:8], 1'b0});
            3'd4: ext_imm = sx ? XLEN'($signed({bus.INST[31:25], bus.INST[11:7]}))
                               : XLEN'({bus.INST[31:25], bus.INST[11:7]});
            3'd5: begin
                // RV32 shifts only have 5 shamt bits; a set bit 25 is an illegal encoding
                if (XLEN == 32) begin
                    ext_imm = XLEN'(bus.INST[24:20]);
                    ext_err = bus.INST[25];
                end else begin
                    ext_imm = XLEN'(bus.INST[25:20]);
                end
            end
            3'd6: ext_imm = XLEN'(bus.INST[19:15]);
            default: ext_err = 1'b1;
        endcase
    end

    assign bus.IN_READY  = (state_q != OCC_TWO);
    assign bus.OUT_VALID = (state_q != OCC_EMPTY);
    assign bus.OUT_IMM   = head_imm;
    assign bus.OUT_TAG   = head_tag;
    assign bus.OUT_ERR   = head_err;
    assign occupancy     = state_q;

    assign push = bus.IN_VALID && bus.IN_READY;
    assign pop  = bus.OUT_VALID && bus.OUT_READY;

    always_comb begin
        state_d        = state_q;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (FLUSH) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: if (push) begin
                    state_d       = OCC_ONE;
                    load_head_new = 1'b1;
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        load_head_new = 1'b1;
                    end else if (push) begin
                        state_d   = OCC_TWO;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: if (pop) begin
                    state_d        = OCC_ONE;
                    load_head_skid = 1'b1;
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= OCC_EMPTY;
            head_imm <= '0;
            head_tag <= '0;
            head_err <= 1'b0;
            skid_imm <= '0;
            skid_tag <= '0;
            skid_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_head_new) begin
                head_imm <= ext_imm;
                head_tag <= bus.IN_TAG;
                head_err <= ext_err;
            end else if (load_head_skid) begin
                head_imm <= skid_imm;
                head_tag <= skid_tag;
                head_err <= skid_err;
            end
            if (load_skid) begin
                skid_imm <= ext_imm;
                skid_tag <= bus.IN_TAG;
                skid_err <= ext_err;
            end
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an RV32 and an RV64 instance driven in lockstep and checked
// against a queue-based reference of the buffer and an arithmetic immediate model.
module tb_imm_gen_pipe;
    localparam int TAG_W = 8;
    localparam int W     = 2 + TAG_W + 64 + 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [1:0] occ32, occ64;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) bus64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .CLK(clk), .RESET(rst_n), .FLUSH(flush), .bus(bus32), .occupancy(occ32)
    );
    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .CLK(clk), .RESET(rst_n), .FLUSH(flush), .bus(bus64), .occupancy(occ64)
    );

    always #5 clk = ~clk;

    // Scoreboard entry: {err32, err64, tag, imm64, imm32}
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_exp;
    logic         in_valid_m, out_ready_m, flush_m;
    int           n_cmp  = 0;
    int           n_fail = 0;

    function automatic logic [W-1:0] pack(input logic [31:0] i32, input logic [63:0] i64,
                                          input logic [TAG_W-1:0] tag,
                                          input logic e32, input logic e64);
        return {e32, e64, tag, i64, i32};
    endfunction

    // Immediates built from field positions with shifts/masks, then extended arithmetically
    function automatic logic [W-1:0] ref_entry(input logic [31:0] inst, input logic [3:0] sel,
                                               input logic [TAG_W-1:0] tag);
        logic [63:0] x, field, v, v32, v64;
        int          width;
        logic        e32, e64;
        x = 64'(inst);
        field = '0; width = 32; e32 = 1'b0; e64 = 1'b0; v32 = '0; v64 = '0;
        case (sel[2:0])
            3'd0: begin field = x & 64'hFFFF_F000; width = 32; end
            3'd1: begin
                field = (((x >> 31) & 64'h1) << 20) | (((x >> 12) & 64'hFF) << 12)
                      | (((x >> 20) & 64'h1) << 11) | (((x >> 21) & 64'h3FF) << 1);
                width = 21;
            end
            3'd2: begin field = (x >> 20) & 64'hFFF; width = 12; end
            3'd3: begin
                field = (((x >> 31) & 64'h1) << 12) | (((x >> 7) & 64'h1) << 11)
                      | (((x >> 25) & 64'h3F) << 5) | (((x >> 8) & 64'hF) << 1);
                width = 13;
            end
            3'd4: begin field = (((x >> 25) & 64'h7F) << 5) | ((x >> 7) & 64'h1F); width = 12; end
            default: ;
        endcase
        if (sel[2:0] <= 3'd4) begin
            if (!sel[3] && ((field >> (width - 1)) & 64'h1) == 64'h1)
                v = field - (64'd1 << width);
            else
                v = field;
            v64 = v;
            v32 = v & 64'hFFFF_FFFF;
        end else if (sel[2:0] == 3'd5) begin
            v32 = (x >> 20) & 64'h1F;
            e32 = x[25];
            v64 = (x >> 20) & 64'h3F;
        end else if (sel[2:0] == 3'd6) begin
            v32 = (x >> 15) & 64'h1F;
            v64 = v32;
        end else begin
            e32 = 1'b1;
            e64 = 1'b1;
        end
        return pack(v32[31:0], v64, tag, e32, e64);
    endfunction

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic check_all();
        logic [W-1:0] e;
        chk("in_ready32", 128'(bus32.IN_READY), 128'(exp_q.size() < 2));
        chk("in_ready64", 128'(bus64.IN_READY), 128'(exp_q.size() < 2));
        chk("out_valid32", 128'(bus32.OUT_VALID), 128'(exp_q.size() > 0));
        chk("out_valid64", 128'(bus64.OUT_VALID), 128'(exp_q.size() > 0));
        chk("occ32", 128'(occ32), 128'(exp_q.size()));
        chk("occ64", 128'(occ64), 128'(exp_q.size()));
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("imm32", 128'(bus32.OUT_IMM), 128'(e[31:0]));
            chk("imm64", 128'(bus64.OUT_IMM), 128'(e[95:32]));
            chk("tag32", 128'(bus32.OUT_TAG), 128'(e[103:96]));
            chk("tag64", 128'(bus64.OUT_TAG), 128'(e[103:96]));
            chk("err64", 128'(bus64.OUT_ERR), 128'(e[104]));
            chk("err32", 128'(bus32.OUT_ERR), 128'(e[105]));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_valid32"}, 128'(bus32.OUT_VALID), 128'(0));
        chk({name, "_valid64"}, 128'(bus64.OUT_VALID), 128'(0));
        chk({name, "_imm32"}, 128'(bus32.OUT_IMM), 128'(0));
        chk({name, "_imm64"}, 128'(bus64.OUT_IMM), 128'(0));
        chk({name, "_tag32"}, 128'(bus32.OUT_TAG), 128'(0));
        chk({name, "_tag64"}, 128'(bus64.OUT_TAG), 128'(0));
        chk({name, "_err32"}, 128'(bus32.OUT_ERR), 128'(0));
        chk({name, "_err64"}, 128'(bus64.OUT_ERR), 128'(0));
        chk({name, "_ready32"}, 128'(bus32.IN_READY), 128'(1));
        chk({name, "_ready64"}, 128'(bus64.IN_READY), 128'(1));
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [3:0] sel,
                         input logic [TAG_W-1:0] tag, input logic ordy, input logic fl,
                         input logic [W-1:0] e);
        bus32.IN_VALID = v;  bus64.IN_VALID = v;
        bus32.INST = inst;   bus64.INST = inst;
        bus32.SELECT = sel;  bus64.SELECT = sel;
        bus32.IN_TAG = tag;  bus64.IN_TAG = tag;
        bus32.OUT_READY = ordy; bus64.OUT_READY = ordy;
        flush = fl;
        in_valid_m = v; out_ready_m = ordy; flush_m = fl; cur_exp = e;
    endtask

    task automatic drive_rand(input logic v, input logic ordy, input logic fl);
        logic [31:0]      inst;
        logic [3:0]       sel;
        logic [TAG_W-1:0] tag;
        inst = $urandom;
        sel  = 4'($urandom_range(0, 15));
        tag  = TAG_W'($urandom);
        drive(v, inst, sel, tag, ordy, fl, ref_entry(inst, sel, tag));
    endtask

    // One clock: update the reference queue for this edge, then compare on the falling edge
    task automatic tick();
        bit can_push, can_pop;
        can_push = in_valid_m && (exp_q.size() < 2);
        can_pop  = out_ready_m && (exp_q.size() > 0);
        @(posedge clk);
        if (flush_m) begin
            exp_q.delete();
        end else begin
            if (can_pop) void'(exp_q.pop_front());
            if (can_push) exp_q.push_back(cur_exp);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic directed(input logic [31:0] inst, input logic [3:0] sel,
                            input logic [TAG_W-1:0] tag, input logic [31:0] e32v,
                            input logic [63:0] e64v, input logic er32, input logic er64);
        drive(1'b1, inst, sel, tag, 1'b1, 1'b0, pack(e32v, e64v, tag, er32, er64));
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 4'h0, '0, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Hand-computed immediates, streamed back to back with OUT_READY=1
        directed(32'hFFF00093, 4'b0010, 8'h01, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
        directed(32'hFFF00093, 4'b1010, 8'h02, 32'h00000FFF, 64'h0000000000000FFF, 1'b0, 1'b0);
        directed(32'hFE000EE3, 4'b0011, 8'h03, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0);
        directed(32'h123450B7, 4'b0000, 8'h04, 32'h12345000, 64'h0000000012345000, 1'b0, 1'b0);
        directed(32'h800000B7, 4'b0000, 8'h05, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0, 1'b0);
        directed(32'h800000B7, 4'b1000, 8'h06, 32'h80000000, 64'h0000000080000000, 1'b0, 1'b0);
        directed(32'hFFDFF06F, 4'b0001, 8'h07, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0);
        directed(32'hFFDFF06F, 4'b1001, 8'h08, 32'h001FFFFC, 64'h00000000001FFFFC, 1'b0, 1'b0);
        directed(32'hFE112C23, 4'b0100, 8'h09, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0, 1'b0);
        directed(32'h01F09093, 4'b0101, 8'h0A, 32'h0000001F, 64'h000000000000001F, 1'b0, 1'b0);
        directed(32'h02009093, 4'b0101, 8'h0B, 32'h00000000, 64'h0000000000000020, 1'b1, 1'b0);
        directed(32'h305F5073, 4'b0110, 8'h0C, 32'h0000001E, 64'h000000000000001E, 1'b0, 1'b0);
        directed(32'h12345678, 4'b0111, 8'h0D, 32'h00000000, 64'h0000000000000000, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 4'h0, '0, 1'b1, 1'b0, '0);
        tick();

        // Backpressure: tags 1,2,3 offered while stalled, then drained in order
        for (int t = 1; t <= 3; t++) begin
            drive(1'b1, 32'hFFF00093, 4'b0010, TAG_W'(t), 1'b0, 1'b0,
                  ref_entry(32'hFFF00093, 4'b0010, TAG_W'(t)));
            tick();
        end
        drive(1'b1, 32'hFFF00093, 4'b0010, 8'd3, 1'b1, 1'b0,
              ref_entry(32'hFFF00093, 4'b0010, 8'd3));
        tick();
        tick();
        drive(1'b0, 32'h0, 4'h0, '0, 1'b1, 1'b0, '0);
        repeat (3) tick();

        // Continuous stream at full throughput
        for (int i = 0; i < 16; i++) begin
            drive_rand(1'b1, 1'b1, 1'b0);
            tick();
        end

        // Flush with two entries held and a new input offered in the flush cycle
        drive_rand(1'b1, 1'b0, 1'b0);
        tick();
        drive_rand(1'b1, 1'b0, 1'b0);
        tick();
        drive_rand(1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 4'h0, '0, 1'b1, 1'b0, '0);
        repeat (2) tick();

        // Random traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            drive_rand($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 31) == 0);
            tick();
        end

        // Asynchronous reset while two entries are held
        drive(1'b1, 32'hFFF00093, 4'b0010, 8'hA1, 1'b0, 1'b0,
              ref_entry(32'hFFF00093, 4'b0010, 8'hA1));
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        exp_q.delete();
        drive(1'b0, 32'h0, 4'h0, '0, 1'b1, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
        directed(32'h123450B7, 4'b0000, 8'h5A, 32'h12345000, 64'h0000000012345000, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 4'h0, '0, 1'b1, 1'b0, '0);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
